mux_scan_sel: RTL and testbench



---
 rtl/mux_scan_sel.sv | 173 +++++++++++++++++
 tb/tb_mux_scan_sel.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sel.sv
// mux_scan_sel: registered N-channel word multiplexer with manual-select and
// autonomous scan modes. Scan mode walks the enabled channels (ch_en), spending
// DWELL cycles on each, and pulses scan_done when the walk wraps around.
// Optional build macro MUX_HOLD_LAST_EN: when defined, out keeps its last valid
// word whenever out_valid is low instead of being forced to zero.
// dbg_state exposes the FSM state (0 = IDLE, 1 = MANUAL, 2 = SCAN).
module mux_scan_sel #(
  parameter int WIDTH = 8,
  parameter int CH    = 8,
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]    sel,
  input  logic                mode,
  input  logic                start,
  input  logic [CH-1:0]       ch_en,
  output logic [WIDTH-1:0]    out,
  output logic                out_valid,
  output logic [SEL_W-1:0]    cur_ch,
  output logic                scan_done,
  output logic [1:0]          dbg_state
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

`ifdef MUX_HOLD_LAST_EN
  localparam bit HOLD_LAST = 1'b1;
`else
  localparam bit HOLD_LAST = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              valid_q, valid_d;
  logic [SEL_W-1:0]  cur_ch_q, cur_ch_d;
  logic              done_q, done_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;

  // Word of channel idx; indices >= CH return zero.
  function automatic logic [WIDTH-1:0] pick(input logic [CH*WIDTH-1:0] bus,
                                            input logic [SEL_W-1:0] idx);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < CH; k++) begin
      if (idx == SEL_W'(k)) r = bus[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  logic             sel_legal;
  logic             cur_en;
  logic             any_en;
  logic [SEL_W-1:0] lowest_ch;
  logic [SEL_W-1:0] above_ch;
  logic             above_found;
  logic [SEL_W-1:0] next_ch;
  logic             next_wraps;

  // Channel search: lowest enabled channel, and the lowest enabled one above cur_ch.
  always_comb begin
    sel_legal   = 1'b0;
    cur_en      = 1'b0;
    any_en      = 1'b0;
    lowest_ch   = '0;
    above_ch    = '0;
    above_found = 1'b0;
    for (int k = CH - 1; k >= 0; k--) begin
      if (sel == SEL_W'(k)) sel_legal = 1'b1;
      if (cur_ch_q == SEL_W'(k)) cur_en = ch_en[k];
      if (ch_en[k]) begin
        any_en    = 1'b1;
        lowest_ch = SEL_W'(k);
        if (SEL_W'(k) > cur_ch_q) begin
          above_found = 1'b1;
          above_ch    = SEL_W'(k);
        end
      end
    end
    next_ch    = above_found ? above_ch : lowest_ch;
    next_wraps = ~above_found;
  end

  // Next-state and next-output logic for the IDLE / MANUAL / SCAN controller.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    valid_d  = valid_q;
    cur_ch_d = cur_ch_q;
    done_d   = 1'b0;
    dwell_d  = dwell_q;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        dwell_d = '0;
        if (!mode) begin
          state_d = ST_MANUAL;
        end else if (start) begin
          state_d  = ST_SCAN;
          cur_ch_d = lowest_ch;
        end
      end
      ST_MANUAL: begin
        if (mode) begin
          // Leaving manual always passes through IDLE; out keeps its value.
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else begin
          cur_ch_d = sel;
          valid_d  = sel_legal;
          out_d    = sel_legal ? pick(in_bus, sel) : (HOLD_LAST ? out_q : '0);
        end
      end
      ST_SCAN: begin
        // Output follows cur_ch with one cycle of lag; a disabled channel reads invalid.
        valid_d = cur_en;
        out_d   = cur_en ? pick(in_bus, cur_ch_q) : (HOLD_LAST ? out_q : '0);
        if (!mode) begin
          state_d = ST_MANUAL;
          dwell_d = '0;
        end else if (any_en) begin
          // Advance at end of dwell, or at once if the current channel was disabled.
          if (!cur_en || dwell_q == DWELL_LAST) begin
            cur_ch_d = next_ch;
            dwell_d  = '0;
            done_d   = next_wraps;
          end else begin
            dwell_d = dwell_q + DW_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      out_q    <= '0;
      valid_q  <= 1'b0;
      cur_ch_q <= '0;
      done_q   <= 1'b0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      cur_ch_q <= cur_ch_d;
      done_q   <= done_d;
      dwell_q  <= dwell_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign cur_ch    = cur_ch_q;
  assign scan_done = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench for mux_scan_sel: an 8-channel instance for manual, scan,
// mask-edit, mode-switch and reset sequences, plus a 6-channel instance for
// the illegal-select case. Expected words are queued as stimulus is applied
// and popped after each clock edge.
module tb_mux_scan_sel;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAN  = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;

`ifdef MUX_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  // Clock and reset.
  logic clk = 1'b0;
  always #10 clk = ~clk;
  logic rst_n;

  logic [63:0] in_bus;
  logic [2:0]  sel;
  logic        mode;
  logic        start;
  logic [7:0]  ch_en;
  logic [5:0]  ch_en6;

  logic [7:0]  out,  out6;
  logic        out_valid, out_valid6;
  logic [2:0]  cur_ch, cur_ch6;
  logic        scan_done, scan_done6;
  logic [1:0]  dbg_state, dbg_state6;

  mux_scan_sel #(.WIDTH(8), .CH(8), .SEL_W(3), .DWELL(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel(sel), .mode(mode),
    .start(start), .ch_en(ch_en), .out(out), .out_valid(out_valid),
    .cur_ch(cur_ch), .scan_done(scan_done), .dbg_state(dbg_state)
  );

  mux_scan_sel #(.WIDTH(8), .CH(6), .SEL_W(3), .DWELL(4)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus[47:0]), .sel(sel), .mode(mode),
    .start(start), .ch_en(ch_en6), .out(out6), .out_valid(out_valid6),
    .cur_ch(cur_ch6), .scan_done(scan_done6), .dbg_state(dbg_state6)
  );

  // Scoreboard: {state, out, valid, cur_ch, scan_done}
  logic [14:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int step  = 0;

  function automatic logic [7:0] chv(input int k);
    return 8'(8'hA0 + k);
  endfunction

  function automatic logic [14:0] e(input logic [1:0] st, input logic [7:0] o,
                                    input logic v, input logic [2:0] c, input logic d);
    return {st, o, v, c, d};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] expv);
    n_cmp++;
    assert (got === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  // Drive one edge: queue expectation, clock, pop and compare.
  task automatic cyc(input logic [14:0] x);
    logic [14:0] ex;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    step++;
    ex = exp_q.pop_front();
    check($sformatf("s%0d.state", step), 8'(dbg_state), 8'(ex[14:13]));
    check($sformatf("s%0d.out",   step), out,            ex[12:5]);
    check($sformatf("s%0d.valid", step), 8'(out_valid), 8'(ex[4]));
    check($sformatf("s%0d.cur",   step), 8'(cur_ch),    8'(ex[3:1]));
    check($sformatf("s%0d.done",  step), 8'(scan_done), 8'(ex[0]));
  endtask

  int scan_list[5] = '{0, 2, 5, 7, 0};

  initial begin
    for (int k = 0; k < 8; k++) in_bus[k*8 +: 8] = chv(k);
    rst_n = 1'b0; sel = '0; mode = 1'b0; start = 1'b0;
    ch_en = 8'hA5; ch_en6 = 6'h3F;

    // Reset state.
    cyc(e(S_IDLE, 8'h00, 0, 0, 0));
    cyc(e(S_IDLE, 8'h00, 0, 0, 0));

    // IDLE -> MANUAL.
    rst_n = 1'b1;
    cyc(e(S_MAN, 8'h00, 0, 0, 0));

    // Manual sweep; 6-channel instance sees sel 6,7 as illegal.
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      cyc(e(S_MAN, chv(s), 1, 3'(s), 0));
      if (s >= 6) begin
        check($sformatf("ill%0d.out", s), out6, HOLD ? chv(5) : 8'h00);
        check($sformatf("ill%0d.valid", s), 8'(out_valid6), 8'h00);
        check($sformatf("ill%0d.cur", s), 8'(cur_ch6), 8'(s));
      end
    end

    // MANUAL -> IDLE, waits for start.
    mode = 1'b1;
    cyc(e(S_IDLE, chv(7), 0, 7, 0));
    cyc(e(S_IDLE, chv(7), 0, 7, 0));

    // Start scan over mask 1010_0101.
    start = 1'b1;
    cyc(e(S_SCAN, chv(7), 0, 0, 0));
    start = 1'b0;
    for (int p = 0; p < 4; p++)
      for (int d = 0; d < 4; d++)
        cyc(e(S_SCAN, chv(scan_list[p]), 1, 3'(d == 3 ? scan_list[p+1] : scan_list[p]),
              (d == 3 && p == 3)));

    // Dwell on 0, move to 2, one cycle in, then clear ch_en[2].
    for (int d = 0; d < 4; d++) cyc(e(S_SCAN, chv(0), 1, (d == 3) ? 3'd2 : 3'd0, 0));
    cyc(e(S_SCAN, chv(2), 1, 2, 0));
    ch_en = 8'hA1;
    cyc(e(S_SCAN, HOLD ? chv(2) : 8'h00, 0, 5, 0));

    // Empty mask: frozen, invalid, no done.
    ch_en = 8'h00;
    cyc(e(S_SCAN, HOLD ? chv(2) : 8'h00, 0, 5, 0));
    cyc(e(S_SCAN, HOLD ? chv(2) : 8'h00, 0, 5, 0));

    // Single channel 0: wrap from 5, then done every 4 cycles.
    ch_en = 8'h01;
    cyc(e(S_SCAN, HOLD ? chv(2) : 8'h00, 0, 0, 1));
    for (int p = 0; p < 2; p++)
      for (int d = 0; d < 4; d++)
        cyc(e(S_SCAN, chv(0), 1, 0, (d == 3)));

    // Back to full mask, advance to channel 5.
    ch_en = 8'hA5;
    for (int p = 0; p < 2; p++)
      for (int d = 0; d < 4; d++)
        cyc(e(S_SCAN, chv(scan_list[p]), 1, 3'(d == 3 ? scan_list[p+1] : scan_list[p]), 0));
    cyc(e(S_SCAN, chv(5), 1, 5, 0));

    // Mode switch to manual with sel = 3.
    mode = 1'b0; sel = 3'd3;
    cyc(e(S_MAN, chv(5), 1, 5, 0));
    cyc(e(S_MAN, chv(3), 1, 3, 0));
    mode = 1'b1;
    cyc(e(S_IDLE, chv(3), 0, 3, 0));
    cyc(e(S_IDLE, chv(3), 0, 3, 0));

    // Reset mid-scan.
    start = 1'b1;
    cyc(e(S_SCAN, chv(3), 0, 0, 0));
    start = 1'b0;
    cyc(e(S_SCAN, chv(0), 1, 0, 0));
    cyc(e(S_SCAN, chv(0), 1, 0, 0));
    rst_n = 1'b0;
    cyc(e(S_IDLE, 8'h00, 0, 0, 0));
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(e(S_IDLE, 8'h00, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
